// File: rtl/vsm_keypad_operand_entry_if.sv
// Keypad-to-accumulator signal bundle: row sense, column drive, key code and load/clear strobes.
// master = keypad scanner, slave = keypad matrix / accumulators side.
interface vsm_keypad_operand_entry_if;
  logic [3:0] KeyRow;
  logic [3:0] KeyCol;
  logic [3:0] Kbd;
  logic       LatchA;
  logic       LatchB;
  logic       OperandSel;
  logic       KeyHeld;
  logic       ClearOut;

  modport master (
    input  KeyRow,
    output KeyCol, Kbd, LatchA, LatchB, OperandSel, KeyHeld, ClearOut
  );

  modport slave (
    output KeyRow,
    input  KeyCol, Kbd, LatchA, LatchB, OperandSel, KeyHeld, ClearOut
  );
endinterface

// File: rtl/vsm_keypad_operand_entry.sv
// 4x4 keypad scanner with press/release debounce and alternating A/B operand load strobes.
// Optional CLEAR_KEY_EN: key 4'hF becomes a clear key (ClearOut pulse, OperandSel back to A).
//
// state    | meaning
// S_SCAN   | rotate one-hot column drive, sample rows on last dwell cycle
// S_PRESS  | column frozen, count stable samples of the recorded row pattern
// S_ACCEPT | key code and KeyHeld are valid, strobe follows next cycle
// S_STROBE | one-cycle LatchA/LatchB (or ClearOut) pulse, OperandSel updates
// S_REL    | wait for all rows released for a full debounce window
module vsm_keypad_operand_entry #(
  parameter int SCAN_DWELL      = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                       MainClock,
  input  logic                       Clear,
  vsm_keypad_operand_entry_if.master bus
);

  localparam int DW_W = $clog2(SCAN_DWELL) + 1;
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DW_W-1:0] DW_LAST = DW_W'(SCAN_DWELL - 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_TERM = DB_W'(DEBOUNCE_CYCLES);

  typedef enum logic [2:0] {
    S_SCAN   = 3'd0,
    S_PRESS  = 3'd1,
    S_ACCEPT = 3'd2,
    S_STROBE = 3'd3,
    S_REL    = 3'd4
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [3:0]      r_row_s1, r_row_s2;
  logic [1:0]      r_col, w_col_nxt;
  logic [1:0]      r_row_idx, w_row_idx_nxt;
  logic [3:0]      r_row_pat, w_row_pat_nxt;
  logic [DW_W-1:0] r_dwell, w_dwell_nxt;
  logic [DB_W-1:0] r_db_cnt, w_db_cnt_nxt;
  logic [3:0]      r_kbd, w_kbd_nxt;
  logic            r_latch_a, w_latch_a_nxt;
  logic            r_latch_b, w_latch_b_nxt;
  logic            r_opsel, w_opsel_nxt;
  logic            r_key_held, w_key_held_nxt;

  logic [3:0]      w_row_low;
  logic            w_none_low;
  logic            w_one_low;
  logic [1:0]      w_row_enc;
  logic [3:0]      w_code;
  logic            w_clr_key;

  assign w_row_low  = ~r_row_s2;
  assign w_none_low = (w_row_low == 4'b0000);
  assign w_one_low  = !w_none_low && ((w_row_low & (w_row_low - 4'd1)) == 4'b0000);
  assign w_code     = {r_row_idx, r_col};

  always_comb begin
    w_row_enc = 2'd0;
    case (w_row_low)
      4'b0010: w_row_enc = 2'd1;
      4'b0100: w_row_enc = 2'd2;
      4'b1000: w_row_enc = 2'd3;
      default: w_row_enc = 2'd0;
    endcase
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_col_nxt      = r_col;
    w_row_idx_nxt  = r_row_idx;
    w_row_pat_nxt  = r_row_pat;
    w_dwell_nxt    = r_dwell;
    w_db_cnt_nxt   = r_db_cnt;
    w_kbd_nxt      = r_kbd;
    w_opsel_nxt    = r_opsel;
    w_key_held_nxt = r_key_held;

    case (r_state)
      S_SCAN: begin
        if (r_dwell >= DW_LAST) begin
          w_dwell_nxt = '0;
          // Multiple rows low is ambiguous, so it is scanned past like an idle column.
          if (w_one_low) begin
            w_row_idx_nxt = w_row_enc;
            w_row_pat_nxt = r_row_s2;
            w_db_cnt_nxt  = '0;
            w_state_nxt   = S_PRESS;
          end else begin
            w_col_nxt = r_col + 2'd1;
          end
        end else begin
          w_dwell_nxt = r_dwell + DW_W'(1);
        end
      end

      S_PRESS: begin
        if (r_row_s2 != r_row_pat) begin
          w_db_cnt_nxt = '0;
          w_dwell_nxt  = '0;
          w_state_nxt  = S_SCAN;
        end else if (r_db_cnt >= DB_LAST) begin
          // Code is published here so it is stable a full cycle ahead of the strobe.
          w_db_cnt_nxt   = DB_TERM;
          w_key_held_nxt = 1'b1;
          if (!w_clr_key) begin
            w_kbd_nxt = w_code;
          end
          w_state_nxt = S_ACCEPT;
        end else begin
          w_db_cnt_nxt = r_db_cnt + DB_W'(1);
        end
      end

      S_ACCEPT: begin
        w_state_nxt = S_STROBE;
      end

      S_STROBE: begin
        w_db_cnt_nxt = '0;
        w_opsel_nxt  = w_clr_key ? 1'b0 : ~r_opsel;
        w_state_nxt  = S_REL;
      end

      S_REL: begin
        if (!w_none_low) begin
          w_db_cnt_nxt = '0;
        end else if (r_db_cnt >= DB_LAST) begin
          w_db_cnt_nxt   = '0;
          w_key_held_nxt = 1'b0;
          w_col_nxt      = r_col + 2'd1;
          w_dwell_nxt    = '0;
          w_state_nxt    = S_SCAN;
        end else begin
          w_db_cnt_nxt = r_db_cnt + DB_W'(1);
        end
      end

      default: begin
        w_state_nxt  = S_SCAN;
        w_dwell_nxt  = '0;
        w_db_cnt_nxt = '0;
      end
    endcase
  end

  assign w_latch_a_nxt = (w_state_nxt == S_STROBE) && !r_opsel && !w_clr_key;
  assign w_latch_b_nxt = (w_state_nxt == S_STROBE) &&  r_opsel && !w_clr_key;

  always_ff @(posedge MainClock or posedge Clear) begin
    if (Clear) begin
      r_state    <= S_SCAN;
      r_row_s1   <= 4'hF;
      r_row_s2   <= 4'hF;
      r_col      <= 2'd0;
      r_row_idx  <= 2'd0;
      r_row_pat  <= 4'hF;
      r_dwell    <= '0;
      r_db_cnt   <= '0;
      r_kbd      <= 4'h0;
      r_latch_a  <= 1'b0;
      r_latch_b  <= 1'b0;
      r_opsel    <= 1'b0;
      r_key_held <= 1'b0;
    end else begin
      r_row_s1   <= bus.KeyRow;
      r_row_s2   <= r_row_s1;
      r_state    <= w_state_nxt;
      r_col      <= w_col_nxt;
      r_row_idx  <= w_row_idx_nxt;
      r_row_pat  <= w_row_pat_nxt;
      r_dwell    <= w_dwell_nxt;
      r_db_cnt   <= w_db_cnt_nxt;
      r_kbd      <= w_kbd_nxt;
      r_latch_a  <= w_latch_a_nxt;
      r_latch_b  <= w_latch_b_nxt;
      r_opsel    <= w_opsel_nxt;
      r_key_held <= w_key_held_nxt;
    end
  end

`ifdef CLEAR_KEY_EN
  logic r_clear_out;

  assign w_clr_key = (w_code == 4'hF);

  always_ff @(posedge MainClock or posedge Clear) begin
    if (Clear) begin
      r_clear_out <= 1'b0;
    end else begin
      r_clear_out <= (w_state_nxt == S_STROBE) && w_clr_key;
    end
  end

  assign bus.ClearOut = r_clear_out;
`else
  assign w_clr_key    = 1'b0;
  assign bus.ClearOut = 1'b0;
`endif

  assign bus.KeyCol     = ~(4'b0001 << r_col);
  assign bus.Kbd        = r_kbd;
  assign bus.LatchA     = r_latch_a;
  assign bus.LatchB     = r_latch_b;
  assign bus.OperandSel = r_opsel;
  assign bus.KeyHeld    = r_key_held;

endmodule

// File: tb/tb_vsm_keypad_operand_entry.sv
// Self-checking bench: keypad matrix model plus a transaction-level model of accepted keys.
// Build with +define+CLEAR_KEY_EN to exercise the clear-key variant.
module tb_vsm_keypad_operand_entry;

  localparam int DW = 4;
  localparam int DB = 16;

  logic MainClock = 1'b0;
  logic Clear     = 1'b1;
  always #5 MainClock = ~MainClock;

  vsm_keypad_operand_entry_if bus();

  vsm_keypad_operand_entry #(.SCAN_DWELL(DW), .DEBOUNCE_CYCLES(DB)) dut (
    .MainClock (MainClock),
    .Clear     (Clear),
    .bus       (bus)
  );

  // Keypad matrix: a pressed key pulls its row low while its column is driven low.
  logic [15:0] keys = '0;
  logic [3:0]  key_row;
  always_comb begin
    key_row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !bus.KeyCol[c]) key_row[r] = 1'b0;
  end
  assign bus.KeyRow = key_row;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: records every strobe seen by the accumulators.
  int cyc = 0;
  always @(posedge MainClock) cyc <= cyc + 1;

  logic [3:0] prev_col = 4'hE;
  logic [3:0] prev_kbd = 4'h0;
  int col_entry   = 0;
  int col_changes = 0;
  int ev_cyc[$], ev_entry[$], ev_kind[$];
  logic [3:0] ev_kbd[$], ev_kbd_prev[$];
  logic ev_held[$], ev_sel[$];

  always @(negedge MainClock) begin
    if (Clear) begin
      col_entry = cyc;
    end else begin
      if (bus.KeyCol !== prev_col) begin
        col_entry = cyc;
        col_changes++;
      end
      if (bus.LatchA || bus.LatchB || bus.ClearOut) begin
        chk("latch_excl", {31'd0, bus.LatchA & bus.LatchB}, 0);
        ev_cyc.push_back(cyc);
        ev_entry.push_back(col_entry);
        ev_kind.push_back(int'({bus.ClearOut, bus.LatchB, bus.LatchA}));
        ev_kbd.push_back(bus.Kbd);
        ev_kbd_prev.push_back(prev_kbd);
        ev_held.push_back(bus.KeyHeld);
        ev_sel.push_back(bus.OperandSel);
      end
    end
    prev_col = bus.KeyCol;
    prev_kbd = bus.Kbd;
  end

  // Reference model state: last loaded code and next target accumulator.
  logic [3:0] model_kbd = 4'h0;
  logic       model_sel = 1'b0;

  task automatic step(input int n);
    repeat (n) @(posedge MainClock);
    #1;
  endtask

  task automatic wait_col_leave(input int c);
    logic [3:0] target;
    int k;
    target = ~(4'b0001 << ((c + 1) % 4));
    k = 0;
    while (bus.KeyCol !== target && k < 200) begin step(1); k++; end
    chk("col_reach", bus.KeyCol, target);
  endtask

  task automatic wait_event(input int n0);
    int k;
    k = 0;
    while (ev_cyc.size() == n0 && k < 300) begin step(1); k++; end
  endtask

  task automatic wait_release();
    int k;
    k = 0;
    while (bus.KeyHeld && k < 200) begin step(1); k++; end
    chk("held_lo", bus.KeyHeld, 0);
  endtask

  task automatic check_event(input int n0, input logic [3:0] code, input bit exact);
    bit clr;
    int exp_kind;
    clr = 1'b0;
`ifdef CLEAR_KEY_EN
    clr = (code == 4'hF);
`endif
    chk("n_strobe", ev_cyc.size() - n0, 1);
    if (ev_cyc.size() > n0) begin
      chk("sel_at_strobe", ev_sel[n0], model_sel);
      if (clr) begin
        exp_kind  = 4;
        model_sel = 1'b0;
      end else begin
        exp_kind  = model_sel ? 2 : 1;
        model_kbd = code;
        model_sel = ~model_sel;
      end
      chk("strobe_kind", ev_kind[n0], exp_kind);
      chk("kbd_at_strobe", ev_kbd[n0], model_kbd);
      chk("kbd_before", ev_kbd_prev[n0], model_kbd);
      chk("held_at_strobe", ev_held[n0], 1);
      if (exact) chk("latency", ev_cyc[n0] - ev_entry[n0], DB + DW + 1);
    end
    chk("opsel", bus.OperandSel, model_sel);
    chk("kbd", bus.Kbd, model_kbd);
    chk("clear_out_idle", bus.ClearOut, 0);
  endtask

  task automatic press_release(input int r, input int c, input int hold);
    int n0;
    n0 = ev_cyc.size();
    wait_col_leave(c);
    keys[r*4+c] = 1'b1;
    wait_event(n0);
    step(hold);
    chk("held_hi", bus.KeyHeld, 1);
    keys = '0;
    wait_release();
    step(3);
    check_event(n0, 4'(r*4+c), 1'b1);
  endtask

  task automatic check_reset_outputs();
    chk("rst_keycol", bus.KeyCol, 4'b1110);
    chk("rst_kbd", bus.Kbd, 0);
    chk("rst_latch_a", bus.LatchA, 0);
    chk("rst_latch_b", bus.LatchB, 0);
    chk("rst_opsel", bus.OperandSel, 0);
    chk("rst_held", bus.KeyHeld, 0);
    chk("rst_clear_out", bus.ClearOut, 0);
  endtask

  initial begin
    int n0, c0, t_last, ge, lat, k;

    step(3);
    check_reset_outputs();
    Clear = 1'b0;
    step(2);

    // Two consecutive keys load A then B.
    press_release(2, 1, 25);
    press_release(0, 3, 10);

    // Release bounce: a short re-press during release debounce restarts the count.
    n0 = ev_cyc.size();
    wait_col_leave(2);
    keys[1*4+2] = 1'b1;
    wait_event(n0);
    step(3);
    keys = '0;
    step(5);
    keys[1*4+2] = 1'b1;
    step(3);
    keys = '0;
    ge = cyc;
    step(DB + 1);
    chk("rel_held_hold", bus.KeyHeld, 1);
    step(1);
    chk("rel_held_drop", bus.KeyHeld, 0);
    step(3);
    check_event(n0, 4'h6, 1'b1);

    // Two rows low in one column: ignored, scanning keeps rotating.
    n0 = ev_cyc.size();
    c0 = col_changes;
    keys[0*4+2] = 1'b1;
    keys[1*4+2] = 1'b1;
    step(64);
    chk("multi_nostrobe", ev_cyc.size() - n0, 0);
    chk("multi_rotate", {31'd0, (col_changes - c0) >= 15}, 1);
    keys = '0;
    step(5);

    // Second key in another column while the first is held: ignored.
    n0 = ev_cyc.size();
    wait_col_leave(0);
    keys[1*4+0] = 1'b1;
    wait_event(n0);
    keys[2*4+3] = 1'b1;
    step(30);
    chk("frozen_col", bus.KeyCol, 4'b1110);
    keys[2*4+3] = 1'b0;
    step(5);
    keys = '0;
    wait_release();
    step(3);
    check_event(n0, 4'h4, 1'b1);

    // Key 4'hF: clear key or ordinary operand depending on build.
    press_release(3, 3, 8);

    // Press bounce: toggling every 5 cycles, ending pressed.
    n0 = ev_cyc.size();
    wait_col_leave(1);
    t_last = cyc;
    for (int i = 0; i < 13; i++) begin
      keys[3*4+1] = (i % 2 == 0);
      t_last = cyc;
      step(5);
    end
    wait_event(n0);
    lat = (ev_cyc.size() > n0) ? ev_cyc[n0] - t_last : -1;
    chk("bounce_lat_win", {31'd0, (lat >= DB + 4) && (lat <= DB + 3 + 4*DW)}, 1);
    step(5);
    keys = '0;
    wait_release();
    step(3);
    check_event(n0, 4'hD, 1'b0);

    // Clear asserted mid press-debounce: reset values, no strobe.
    n0 = ev_cyc.size();
    wait_col_leave(2);
    keys[2*4+2] = 1'b1;
    k = 0;
    while (bus.KeyCol !== 4'b1011 && k < 200) begin step(1); k++; end
    step(DW + 5);
    #2 Clear = 1'b1;
    #1 check_reset_outputs();
    keys = '0;
    model_kbd = 4'h0;
    model_sel = 1'b0;
    step(2);
    Clear = 1'b0;
    step(40);
    chk("rst_nostrobe", ev_cyc.size() - n0, 0);

    // Random keys against the model.
    for (int i = 0; i < 12; i++) begin
      press_release(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 20)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
